// File: rtl/src_pkg.sv
// Shared definitions for the Mini SRC datapath.
//   - bus source codes driven on BusDataSelect
//   - ALU operation codes driven on ALU_op
//   - RAM geometry and data width
package src_pkg;

   localparam int DATA_W    = 32;
   localparam int RAM_DEPTH = 512;
   localparam int RAM_AW    = 9;

   // Bus source codes; 0-15 select R0-R15 directly.
   localparam logic [4:0] BUS_HI     = 5'd16;
   localparam logic [4:0] BUS_LO     = 5'd17;
   localparam logic [4:0] BUS_ZHI    = 5'd18;
   localparam logic [4:0] BUS_ZLO    = 5'd19;
   localparam logic [4:0] BUS_PC     = 5'd20;
   localparam logic [4:0] BUS_MDR    = 5'd21;
   localparam logic [4:0] BUS_INPORT = 5'd22;
   localparam logic [4:0] BUS_CSEXT  = 5'd23;
   localparam logic [4:0] BUS_GPR    = 5'd24;

   // ALU operation codes; 14-15 produce zero.
   localparam logic [3:0] ALU_ADD  = 4'd0;
   localparam logic [3:0] ALU_SUB  = 4'd1;
   localparam logic [3:0] ALU_AND  = 4'd2;
   localparam logic [3:0] ALU_OR   = 4'd3;
   localparam logic [3:0] ALU_SHR  = 4'd4;
   localparam logic [3:0] ALU_SHRA = 4'd5;
   localparam logic [3:0] ALU_SHL  = 4'd6;
   localparam logic [3:0] ALU_ROR  = 4'd7;
   localparam logic [3:0] ALU_ROL  = 4'd8;
   localparam logic [3:0] ALU_MUL  = 4'd9;
   localparam logic [3:0] ALU_DIV  = 4'd10;
   localparam logic [3:0] ALU_NEG  = 4'd11;
   localparam logic [3:0] ALU_NOT  = 4'd12;
   localparam logic [3:0] ALU_PASS = 4'd13;

   // Sign-extend a 32-bit result into the 64-bit Z register.
   function automatic logic [63:0] sext64(input logic [31:0] v);
      return {{32{v[31]}}, v};
   endfunction

endpackage

// File: rtl/src_alu.sv
// Combinational ALU for the Mini SRC datapath.
//   a   in  32  operand A (Y register)
//   b   in  32  operand B (bus or sign-extended immediate)
//   op  in  4   operation code (src_pkg ALU_*)
//   z   out 64  result; MUL gives the full product, DIV gives
//               {remainder, quotient}, everything else is sign-extended
module src_alu
   import src_pkg::*;
(
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  logic [3:0]  op,
   output logic [63:0] z
);

   logic signed [63:0] prod;
   logic signed [31:0] sa, sb, quo, rem;
   logic        [4:0]  sh;
   logic        [63:0] dbl;
   logic        [63:0] rol_t;

   assign sh    = b[4:0];
   // Rotates use a doubled copy so a zero shift needs no special case.
   assign dbl   = {a, a};
   assign rol_t = dbl << sh;

   always_comb begin
      sa   = a;
      sb   = b;
      prod = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
      quo  = '0;
      rem  = '0;
      if (sb != 0) begin
         quo = sa / sb;
         rem = sa % sb;
      end
   end

   always_comb begin
      z = '0;
      case (op)
         ALU_ADD:  z = sext64(a + b);
         ALU_SUB:  z = sext64(a - b);
         ALU_AND:  z = sext64(a & b);
         ALU_OR:   z = sext64(a | b);
         ALU_SHR:  z = sext64(a >> sh);
         ALU_SHRA: z = sext64(32'($signed(a) >>> sh));
         ALU_SHL:  z = sext64(a << sh);
         ALU_ROR:  z = sext64(dbl[31:0] >> sh | dbl[63:32] << (6'd32 - {1'b0, sh}));
         ALU_ROL:  z = sext64(rol_t[63:32]);
         ALU_MUL:  z = prod;
         ALU_DIV:  z = {rem, quo};
         ALU_NEG:  z = sext64(-b);
         ALU_NOT:  z = sext64(~b);
         ALU_PASS: z = sext64(b);
         default:  z = '0;
      endcase
   end

endmodule

// File: rtl/src_datapath.sv
// Mini SRC single-bus datapath, sequenced cycle by cycle by an external
// control unit. Holds PC, IR, MAR, MDR, Y, Z(64), HI, LO, R0-R15, CON,
// in/out ports, a 512x32 RAM and the ALU.
// Ports:
//   clock, clear        clock and synchronous active-low reset
//   incPC, e_*          register load enables
//   ram_read/ram_write  RAM access at MAR[8:0]
//   MDR_read, Mdatain   MDR source select / external memory data
//   ALU_op, imm_sel     ALU operation and B-operand select
//   BusDataSelect       bus source code
//   Gra/Grb/Grc, e_Rout, BAout  select-encode controls
//   inport_data         input port pins
//   bus, pc_q, ir_q, mar_q, outport_data, con_q   observation
module src_datapath
   import src_pkg::*;
(
   input  logic        clock,
   input  logic        clear,
   input  logic        incPC,
   input  logic        e_PC,
   input  logic        e_IR,
   input  logic        e_Y,
   input  logic        e_MAR,
   input  logic        e_HI,
   input  logic        e_LO,
   input  logic        e_Z,
   input  logic        e_MDR,
   input  logic        e_GP,
   input  logic        e_Rin,
   input  logic        e_RA,
   input  logic        e_CON_FF,
   input  logic        e_OutPort,
   input  logic        e_InPort,
   input  logic        ram_read,
   input  logic        ram_write,
   input  logic        MDR_read,
   input  logic [31:0] Mdatain,
   input  logic [3:0]  ALU_op,
   input  logic [4:0]  BusDataSelect,
   input  logic        Gra,
   input  logic        Grb,
   input  logic        Grc,
   input  logic        e_Rout,
   input  logic        BAout,
   input  logic        imm_sel,
   input  logic [31:0] inport_data,
   output logic [31:0] bus,
   output logic [31:0] pc_q,
   output logic [31:0] ir_q,
   output logic [31:0] mar_q,
   output logic [31:0] outport_data,
   output logic        con_q
);

   logic [31:0] pc, ir, mar, mdr, y, hi, lo, inport, outport, ram_q;
   logic [63:0] z;
   logic        con;
   logic [31:0] gpr [16];
   logic [31:0] mem [RAM_DEPTH];

   logic [3:0]  sel_idx;
   logic [31:0] c_sext;
   logic [31:0] alu_b;
   logic [63:0] alu_z;
   logic [31:0] mdr_d;
   logic        con_d;
   logic [RAM_AW-1:0] ram_addr;

   assign ram_addr = mar[RAM_AW-1:0];

   // Select-encode: whichever IR fields are enabled are ORed together.
   assign sel_idx = (ir[26:23] & {4{Gra}})
                  | (ir[22:19] & {4{Grb}})
                  | (ir[18:15] & {4{Grc}});

   assign c_sext = {{13{ir[18]}}, ir[18:0]};

   // Single 32-bit bus, zero latency.
   always_comb begin
      bus = '0;
      if (!BusDataSelect[4]) begin
         bus = gpr[BusDataSelect[3:0]];
      end else begin
         case (BusDataSelect)
            BUS_HI:     bus = hi;
            BUS_LO:     bus = lo;
            BUS_ZHI:    bus = z[63:32];
            BUS_ZLO:    bus = z[31:0];
            BUS_PC:     bus = pc;
            BUS_MDR:    bus = mdr;
            BUS_INPORT: bus = inport;
            BUS_CSEXT:  bus = c_sext;
            // BAout reads R0 as zero so it can serve as a base address.
            BUS_GPR: begin
               if (BAout && sel_idx == 4'd0)
                  bus = '0;
               else if (e_Rout || BAout)
                  bus = gpr[sel_idx];
            end
            default:    bus = '0;
         endcase
      end
   end

   assign alu_b = imm_sel ? c_sext : bus;

   src_alu u_alu (
      .a  (y),
      .b  (alu_b),
      .op (ALU_op),
      .z  (alu_z)
   );

   // ram_q only carries fresh data while ram_read is held, so a memory
   // load keeps ram_read asserted on the cycle MDR captures it.
   always_comb begin
      mdr_d = bus;
      if (MDR_read)
         mdr_d = ram_read ? ram_q : Mdatain;
   end

   always_comb begin
      con_d = 1'b0;
      case (ir[20:19])
         2'b00: con_d = (bus == '0);
         2'b01: con_d = (bus != '0);
         2'b10: con_d = ~bus[31];
         2'b11: con_d = bus[31];
         default: con_d = 1'b0;
      endcase
   end

   always_ff @(posedge clock) begin
      if (!clear) begin
         pc      <= '0;
         ir      <= '0;
         mar     <= '0;
         mdr     <= '0;
         y       <= '0;
         z       <= '0;
         hi      <= '0;
         lo      <= '0;
         inport  <= '0;
         outport <= '0;
         ram_q   <= '0;
         con     <= 1'b0;
         for (int i = 0; i < 16; i++) gpr[i] <= '0;
      end else begin
         if (e_PC)          pc <= bus;
         else if (incPC)    pc <= pc + 32'd1;
         if (e_IR)          ir <= bus;
         if (e_MAR)         mar <= bus;
         if (e_MDR)         mdr <= mdr_d;
         if (e_Y)           y <= bus;
         if (e_Z)           z <= alu_z;
         if (e_HI)          hi <= bus;
         if (e_LO)          lo <= bus;
         if (e_InPort)      inport <= inport_data;
         if (e_OutPort)     outport <= bus;
         if (e_CON_FF)      con <= con_d;
         if (ram_read)      ram_q <= mem[ram_addr];
         if (e_GP && e_Rin) gpr[sel_idx] <= bus;
         // Both GPR write paths carry the bus, so an R15 overlap agrees.
         if (e_RA)          gpr[15] <= bus;
      end
   end

   // RAM contents survive reset; a same-cycle read sees the old word.
   always_ff @(posedge clock) begin
      if (ram_write) mem[ram_addr] <= mdr;
   end

   assign pc_q         = pc;
   assign ir_q         = ir;
   assign mar_q        = mar;
   assign outport_data = outport;
   assign con_q        = con;

endmodule

// File: tb/tb_src_datapath.sv
// Directed bench for src_datapath. Stimulus pushes expected values into a
// scoreboard queue and raises chk_req; a monitor on the falling edge pops
// every pending entry and compares it against the selected DUT output.
module tb_src_datapath;

   logic        clock = 0;
   logic        clear;
   logic        incPC, e_PC, e_IR, e_Y, e_MAR, e_HI, e_LO, e_Z, e_MDR;
   logic        e_GP, e_Rin, e_RA, e_CON_FF, e_OutPort, e_InPort;
   logic        ram_read, ram_write, MDR_read;
   logic [31:0] Mdatain;
   logic [3:0]  ALU_op;
   logic [4:0]  BusDataSelect;
   logic        Gra, Grb, Grc, e_Rout, BAout, imm_sel;
   logic [31:0] inport_data;
   logic [31:0] bus, pc_q, ir_q, mar_q, outport_data;
   logic        con_q;

   src_datapath dut (
      .clock(clock), .clear(clear), .incPC(incPC), .e_PC(e_PC), .e_IR(e_IR),
      .e_Y(e_Y), .e_MAR(e_MAR), .e_HI(e_HI), .e_LO(e_LO), .e_Z(e_Z),
      .e_MDR(e_MDR), .e_GP(e_GP), .e_Rin(e_Rin), .e_RA(e_RA),
      .e_CON_FF(e_CON_FF), .e_OutPort(e_OutPort), .e_InPort(e_InPort),
      .ram_read(ram_read), .ram_write(ram_write), .MDR_read(MDR_read),
      .Mdatain(Mdatain), .ALU_op(ALU_op), .BusDataSelect(BusDataSelect),
      .Gra(Gra), .Grb(Grb), .Grc(Grc), .e_Rout(e_Rout), .BAout(BAout),
      .imm_sel(imm_sel), .inport_data(inport_data), .bus(bus), .pc_q(pc_q),
      .ir_q(ir_q), .mar_q(mar_q), .outport_data(outport_data), .con_q(con_q)
   );

   always #5 clock = ~clock;

   localparam int S_BUS = 0, S_PC = 1, S_MAR = 2, S_IR = 3, S_OUT = 4, S_CON = 5;

   typedef struct {
      int          sel;
      logic [31:0] val;
      string       name;
   } exp_t;

   exp_t q[$];
   logic chk_req = 0;
   int   checks = 0;
   int   errors = 0;

   always @(negedge clock) begin
      if (chk_req) begin
         while (q.size() > 0) begin
            exp_t e;
            logic [31:0] act;
            e = q.pop_front();
            case (e.sel)
               S_BUS:   act = bus;
               S_PC:    act = pc_q;
               S_MAR:   act = mar_q;
               S_IR:    act = ir_q;
               S_OUT:   act = outport_data;
               default: act = {31'd0, con_q};
            endcase
            checks++;
            if (act !== e.val) begin
               errors++;
               $display("FAIL %s: got %h expected %h", e.name, act, e.val);
            end
         end
      end
   end

   task automatic idle();
      {incPC, e_PC, e_IR, e_Y, e_MAR, e_HI, e_LO, e_Z, e_MDR} = '0;
      {e_GP, e_Rin, e_RA, e_CON_FF, e_OutPort, e_InPort} = '0;
      {ram_read, ram_write, MDR_read, Gra, Grb, Grc, e_Rout, BAout, imm_sel} = '0;
      ALU_op = '0;
      BusDataSelect = 5'd25;
   endtask

   task automatic step();
      @(posedge clock);
      #1;
      chk_req = 0;
      idle();
   endtask

   task automatic want(input int sel, input logic [31:0] val, input string name);
      q.push_back('{sel, val, name});
      chk_req = 1;
   endtask

   // Loads the input port, then leaves it driven on the bus for the caller.
   task automatic put_bus(input logic [31:0] v);
      inport_data = v; e_InPort = 1; step();
      BusDataSelect = 5'd22;
   endtask

   task automatic alu_run(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op);
      inport_data = a; e_InPort = 1; step();
      BusDataSelect = 5'd22; e_Y = 1; inport_data = b; e_InPort = 1; step();
      BusDataSelect = 5'd22; ALU_op = op; e_Z = 1; step();
   endtask

   task automatic check_z(input logic [31:0] hi, input logic [31:0] lo, input string name);
      BusDataSelect = 5'd18; want(S_BUS, hi, {name, "_hi"}); step();
      BusDataSelect = 5'd19; want(S_BUS, lo, {name, "_lo"}); step();
   endtask

   task automatic ram_load_mdr();
      ram_read = 1; MDR_read = 1; step();
      ram_read = 1; MDR_read = 1; e_MDR = 1; step();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      idle();
      Mdatain = '0; inport_data = '0;
      clear = 0;
      step();
      clear = 1;
      // reset state
      BusDataSelect = 5'd20;
      want(S_BUS, 32'h0, "rst_bus_pc"); want(S_PC, 32'h0, "rst_pc");
      want(S_MAR, 32'h0, "rst_mar"); want(S_IR, 32'h0, "rst_ir");
      want(S_OUT, 32'h0, "rst_out"); want(S_CON, 32'h0, "rst_con");
      step();

      // PC increment then PC -> MAR
      incPC = 1; step();
      want(S_PC, 32'h1, "inc_pc");
      BusDataSelect = 5'd20; e_MAR = 1; step();
      want(S_MAR, 32'h1, "mar_from_pc"); want(S_PC, 32'h1, "pc_hold");
      step();

      // RAM write/read through MDR at MAR=1
      Mdatain = 32'h12345678; MDR_read = 1; e_MDR = 1; step();
      ram_write = 1; step();
      Mdatain = 32'h0; MDR_read = 1; e_MDR = 1; step();
      ram_load_mdr();
      BusDataSelect = 5'd21; want(S_BUS, 32'h12345678, "ram_read"); step();

      // only MAR[8:0] addresses RAM
      put_bus(32'h201); e_MAR = 1; step();
      want(S_MAR, 32'h201, "mar_201");
      MDR_read = 1; e_MDR = 1; step();
      ram_load_mdr();
      BusDataSelect = 5'd21; want(S_BUS, 32'h12345678, "ram_addr_wrap"); step();

      // same-cycle read/write returns old data, then new data
      Mdatain = 32'hAAAA5555; MDR_read = 1; e_MDR = 1; step();
      ram_write = 1; ram_read = 1; MDR_read = 1; step();
      ram_read = 1; MDR_read = 1; e_MDR = 1; step();
      BusDataSelect = 5'd21; want(S_BUS, 32'h12345678, "rw_old"); step();
      ram_load_mdr();
      BusDataSelect = 5'd21; want(S_BUS, 32'hAAAA5555, "rw_new"); step();

      // IR with Ra field = 3, write R3=5 via select-encode
      put_bus(32'h0180_0000); e_IR = 1; step();
      want(S_IR, 32'h0180_0000, "ir_load");
      put_bus(32'd5); e_GP = 1; e_Rin = 1; Gra = 1; step();
      BusDataSelect = 5'd3; want(S_BUS, 32'd5, "r3_direct"); step();
      put_bus(32'd7); e_Y = 1; step();
      BusDataSelect = 5'd3; ALU_op = 4'd0; e_Z = 1; step();
      check_z(32'h0, 32'd12, "add");

      alu_run(32'h10000, 32'h10000, 4'd9);   check_z(32'h1, 32'h0, "mul");
      alu_run(32'd3, 32'd5, 4'd1);           check_z(32'hFFFFFFFF, 32'hFFFFFFFE, "sub_neg");
      alu_run(32'hFFFFFFF9, 32'd2, 4'd10);   check_z(32'hFFFFFFFF, 32'hFFFFFFFD, "div");
      alu_run(32'd100, 32'd0, 4'd10);        check_z(32'h0, 32'h0, "div0");
      alu_run(32'd1, 32'd1, 4'd7);           check_z(32'hFFFFFFFF, 32'h80000000, "ror");
      alu_run(32'h80000000, 32'd4, 4'd5);    check_z(32'hFFFFFFFF, 32'hF8000000, "shra");
      alu_run(32'h80000001, 32'd1, 4'd8);    check_z(32'h0, 32'h00000003, "rol");

      // immediate operand: C = 0x7FFFF sign-extends to -1
      put_bus(32'h0007FFFF); e_IR = 1; step();
      BusDataSelect = 5'd23; want(S_BUS, 32'hFFFFFFFF, "c_sext"); step();
      put_bus(32'd10); e_Y = 1; step();
      imm_sel = 1; BusDataSelect = 5'd25; ALU_op = 4'd0; e_Z = 1; step();
      check_z(32'h0, 32'd9, "add_imm");

      // CON flip-flop
      put_bus(32'h0); e_IR = 1; step();
      BusDataSelect = 5'd25; e_CON_FF = 1; step();
      want(S_CON, 32'd1, "con_eq0_true");
      put_bus(32'd5); e_CON_FF = 1; step();
      want(S_CON, 32'd0, "con_eq0_false");
      put_bus(32'h0018_0000); e_IR = 1; step();
      put_bus(32'hFFFFFFFF); e_CON_FF = 1; step();
      want(S_CON, 32'd1, "con_lt0");
      put_bus(32'h0010_0000); e_IR = 1; step();
      put_bus(32'hFFFFFFFF); e_CON_FF = 1; step();
      want(S_CON, 32'd0, "con_ge0_neg");
      step();

      // R0 writable; BAout reads it as zero
      put_bus(32'h0); e_IR = 1; step();
      put_bus(32'd9); e_GP = 1; e_Rin = 1; Grb = 1; step();
      BusDataSelect = 5'd24; Grb = 1; BAout = 1; want(S_BUS, 32'h0, "baout_r0"); step();
      BusDataSelect = 5'd24; Grb = 1; e_Rout = 1; want(S_BUS, 32'd9, "rout_r0"); step();
      BusDataSelect = 5'd24; Grb = 1; want(S_BUS, 32'h0, "gpr_no_out"); step();

      // e_RA -> R15, out port
      put_bus(32'hCAFEF00D); e_RA = 1; e_OutPort = 1; step();
      want(S_OUT, 32'hCAFEF00D, "outport");
      BusDataSelect = 5'd15; want(S_BUS, 32'hCAFEF00D, "r15_link"); step();

      // PC load priority and wrap
      put_bus(32'hFFFFFFFF); e_PC = 1; incPC = 1; step();
      want(S_PC, 32'hFFFFFFFF, "pc_load_prio");
      incPC = 1; step();
      want(S_PC, 32'h0, "pc_wrap");
      step();

      // second reset: registers clear, RAM survives
      clear = 0; step(); clear = 1;
      BusDataSelect = 5'd0;
      want(S_BUS, 32'h0, "rst2_r0"); want(S_OUT, 32'h0, "rst2_out");
      step();
      put_bus(32'd1); e_MAR = 1; step();
      ram_load_mdr();
      BusDataSelect = 5'd21; want(S_BUS, 32'hAAAA5555, "ram_keep"); step();
      step();

      checks++;
      if (q.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain: got %0d pending expected 0", q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
